// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bank
// Description : Decoded I/O write-port bank with per-port lock, edge-detected
//               write acceptance and a write-event FIFO. Optional readback is
//               enabled by defining IO_PORT_BANK_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_bank #(
    parameter int                   NPORTS     = 4,
    parameter logic [16*NPORTS-1:0] PORT_ADDR  = {16'h1FFD, 16'hDFFD, 16'h7FFD, 16'h00FE},
    parameter logic [16*NPORTS-1:0] PORT_MASK  = {16'hF002, 16'hFFFF, 16'h8002, 16'h0001},
    parameter logic [NPORTS-1:0]    LOCK_MASK  = 4'b0100,
    parameter int                   LOCK_BIT   = 5,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic                  clk28,
    input  logic                  rst_n,
    input  logic                  bus_ioreq,
    input  logic                  bus_rd,
    input  logic                  bus_wr,
    input  logic [15:0]           bus_a,
    input  logic [7:0]            bus_d,
    input  logic [NPORTS-1:0]     en,
    input  logic                  unlock,
    output logic [8*NPORTS-1:0]   port_q,
    output logic [NPORTS-1:0]     wr_stb,
    output logic [7:0]            d_out,
    output logic                  d_out_active,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [2:0]            ev_port,
    output logic [7:0]            ev_data,
    output logic                  ev_overflow,
    input  logic                  ev_clear
);

    localparam int             c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [NPORTS-1:0] w_match;
    logic [NPORTS-1:0] w_wsel;
    logic [NPORTS-1:0] w_acc;
    logic [NPORTS-1:0] w_locked;
    logic [NPORTS-1:0] r_wsel_q;
    logic [NPORTS-1:0] r_wr_stb;

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_port
            logic [7:0] r_q;
            logic       r_lock;

            assign w_match[i]  = ((bus_a ^ PORT_ADDR[16*i +: 16]) & PORT_MASK[16*i +: 16]) == 16'h0000;
            assign w_wsel[i]   = bus_ioreq & bus_wr & w_match[i] & en[i] & (~r_lock | unlock);
            assign w_acc[i]    = w_wsel[i] & ~r_wsel_q[i];
            assign w_locked[i] = r_lock;
            assign port_q[8*i +: 8] = r_q;

            always_ff @(posedge clk28 or negedge rst_n) begin
                if (!rst_n) begin
                    r_q    <= 8'h00;
                    r_lock <= 1'b0;
                end else if (w_acc[i]) begin
                    r_q <= bus_d;
                    // Override reloads the lock; otherwise a lock can only be set.
                    if (unlock)
                        r_lock <= LOCK_MASK[i] & bus_d[LOCK_BIT];
                    else if (LOCK_MASK[i] & bus_d[LOCK_BIT])
                        r_lock <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel_q <= '0;
            r_wr_stb <= '0;
        end else begin
            r_wsel_q <= w_wsel;
            r_wr_stb <= w_acc;
        end
    end

    assign wr_stb = r_wr_stb;

    logic       w_any_acc;
    logic [2:0] w_low_idx;

    always_comb begin
        w_any_acc = |w_acc;
        w_low_idx = 3'd0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (w_acc[i])
                w_low_idx = 3'(i);
        end
    end

    logic [10:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;

    assign ev_valid   = (r_count != '0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_pop      = ev_valid & ev_ready & ~ev_clear;
    assign w_push_req = w_any_acc & ~ev_clear;
    // A pop in the same clock frees the slot a push into a full FIFO needs.
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (ev_clear) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: ;
            endcase
            if (w_push_req & ~w_push)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk28) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_low_idx, bus_d};
    end

    assign ev_port     = r_mem[r_rd_ptr][10:8];
    assign ev_data     = r_mem[r_rd_ptr][7:0];
    assign ev_overflow = r_overflow;

`ifdef IO_PORT_BANK_READBACK_EN
    logic       r_rd_q;
    logic [7:0] r_d_out;
    logic       w_rb_hit;
    logic [7:0] w_rb_data;

    always_comb begin
        w_rb_hit  = 1'b0;
        w_rb_data = 8'h00;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (w_match[i] & en[i]) begin
                w_rb_hit  = 1'b1;
                w_rb_data = port_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_q  <= 1'b0;
            r_d_out <= 8'h00;
        end else begin
            r_rd_q  <= bus_ioreq & bus_rd & w_rb_hit;
            r_d_out <= w_rb_data;
        end
    end

    assign d_out        = r_d_out;
    assign d_out_active = r_rd_q;
`else
    logic w_unused_rd;
    assign w_unused_rd  = bus_rd;
    assign d_out        = 8'hFF;
    assign d_out_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_bank
// Description : Randomized self-checking bench for io_port_bank against a
//               transaction-level model of ports, locks and the event queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_bank;

    localparam int          NPORTS     = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam int          LOCK_BIT   = 5;
    localparam logic [63:0] PORT_ADDR  = {16'h1FFD, 16'hDFFD, 16'h7FFD, 16'h00FE};
    localparam logic [63:0] PORT_MASK  = {16'hF002, 16'hFFFF, 16'h8002, 16'h0001};
    // Port 1 (7FFD) is made lockable so the lock scenario targets it.
    localparam logic [3:0]  LOCK_MASK  = 4'b0010;

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic        bus_ioreq, bus_rd, bus_wr;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic [3:0]  en;
    logic        unlock;
    logic [31:0] port_q;
    logic [3:0]  wr_stb;
    logic [7:0]  d_out;
    logic        d_out_active;
    logic        ev_valid, ev_ready;
    logic [2:0]  ev_port;
    logic [7:0]  ev_data;
    logic        ev_overflow, ev_clear;

    io_port_bank #(
        .NPORTS(NPORTS), .PORT_ADDR(PORT_ADDR), .PORT_MASK(PORT_MASK),
        .LOCK_MASK(LOCK_MASK), .LOCK_BIT(LOCK_BIT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk28(clk28), .rst_n(rst_n), .bus_ioreq(bus_ioreq), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_a(bus_a), .bus_d(bus_d), .en(en), .unlock(unlock),
        .port_q(port_q), .wr_stb(wr_stb), .d_out(d_out), .d_out_active(d_out_active),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_port(ev_port), .ev_data(ev_data),
        .ev_overflow(ev_overflow), .ev_clear(ev_clear)
    );

    always #18 clk28 = ~clk28;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  m_port [NPORTS];
    bit          m_lock [NPORTS];
    logic [10:0] m_q [$];
    bit          m_ovf;

    task automatic m_reset();
        for (int i = 0; i < NPORTS; i++) begin
            m_port[i] = 8'h00;
            m_lock[i] = 1'b0;
        end
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    function automatic bit m_match(input logic [15:0] a, input int i);
        return ((a ^ PORT_ADDR[16*i +: 16]) & PORT_MASK[16*i +: 16]) == 16'h0000;
    endfunction

    function automatic logic [3:0] m_sel(input logic [15:0] a);
        logic [3:0] s;
        for (int i = 0; i < NPORTS; i++)
            s[i] = m_match(a, i) && en[i] && (!m_lock[i] || unlock);
        return s;
    endfunction

    task automatic m_commit(input logic [3:0] acc, input logic [7:0] d, input bit pop, input bit clr);
        int low = -1;
        for (int i = 0; i < NPORTS; i++) begin
            if (acc[i]) begin
                m_port[i] = d;
                if (unlock)
                    m_lock[i] = LOCK_MASK[i] && d[LOCK_BIT];
                else if (LOCK_MASK[i] && d[LOCK_BIT])
                    m_lock[i] = 1'b1;
                if (low < 0)
                    low = i;
            end
        end
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop && m_q.size() > 0)
                void'(m_q.pop_front());
            if (low >= 0) begin
                if (m_q.size() < FIFO_DEPTH)
                    m_q.push_back({3'(low), d});
                else
                    m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_ports(input string tag);
        for (int i = 0; i < NPORTS; i++)
            check($sformatf("%s.port_q%0d", tag, i), port_q[8*i +: 8], m_port[i]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".port_q"}, port_q, 32'h0);
        check({tag, ".wr_stb"}, wr_stb, 4'h0);
        check({tag, ".ev_valid"}, ev_valid, 1'b0);
        check({tag, ".ev_overflow"}, ev_overflow, 1'b0);
        check({tag, ".d_out_active"}, d_out_active, 1'b0);
    endtask

    // Called at a negedge; returns at a negedge with the bus idle.
    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold,
                            input bit pop_first, input bit clr_first);
        logic [3:0] acc;
        int         stb [NPORTS];
        acc = m_sel(addr);
        for (int i = 0; i < NPORTS; i++) stb[i] = 0;
        if (pop_first && !clr_first && m_q.size() > 0) begin
            check("pop.valid", ev_valid, 1'b1);
            check("pop.head", {ev_port, ev_data}, m_q[0]);
        end
        bus_a = addr; bus_d = data; bus_ioreq = 1'b1; bus_wr = 1'b1;
        ev_ready = pop_first; ev_clear = clr_first;
        @(negedge clk28);
        ev_ready = 1'b0; ev_clear = 1'b0;
        m_commit(acc, data, pop_first, clr_first);
        for (int c = 0; c < hold; c++) begin
            for (int i = 0; i < NPORTS; i++) stb[i] += int'(wr_stb[i]);
            if (c == hold - 1) begin
                bus_ioreq = 1'b0; bus_wr = 1'b0;
            end
            @(negedge clk28);
        end
        for (int i = 0; i < NPORTS; i++) begin
            stb[i] += int'(wr_stb[i]);
            check($sformatf("wr.stb_count%0d", i), stb[i], int'(acc[i]));
        end
        check_ports("wr");
        check("wr.ev_overflow", ev_overflow, m_ovf);
        check("wr.ev_valid", ev_valid, m_q.size() > 0);
    endtask

    task automatic drain();
        int n = m_q.size();
        ev_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check("drain.valid", ev_valid, 1'b1);
            check("drain.entry", {ev_port, ev_data}, m_q[0]);
            void'(m_q.pop_front());
            @(negedge clk28);
        end
        ev_ready = 1'b0;
        check("drain.empty", ev_valid, 1'b0);
        check("drain.ovf", ev_overflow, m_ovf);
    endtask

    task automatic io_read(input logic [15:0] addr);
        bit         hit = 1'b0;
        logic [7:0] exp_d = 8'h00;
        for (int i = 0; i < NPORTS; i++) begin
            if (!hit && m_match(addr, i) && en[i]) begin
                hit   = 1'b1;
                exp_d = m_port[i];
            end
        end
        bus_a = addr; bus_ioreq = 1'b1; bus_rd = 1'b1;
        @(negedge clk28);
`ifdef IO_PORT_BANK_READBACK_EN
        check("rd.active", d_out_active, hit);
        if (hit)
            check("rd.data", d_out, exp_d);
`else
        check("rd.active", d_out_active, 1'b0);
        check("rd.data", d_out, 8'hFF);
`endif
        bus_ioreq = 1'b0; bus_rd = 1'b0;
        @(negedge clk28);
        check("rd.idle", d_out_active, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pool [6];
        logic [3:0]  acc;
        int          stb [NPORTS];
        pool = '{16'h00FE, 16'h7FFD, 16'hDFFD, 16'h1FFD, 16'h3FFD, 16'h0000};

        rst_n = 1'b0; bus_ioreq = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
        bus_a = 16'h0000; bus_d = 8'h00; en = 4'hF; unlock = 1'b0;
        ev_ready = 1'b0; ev_clear = 1'b0;
        m_reset();
        repeat (3) @(negedge clk28);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk28);

        // Long write: one strobe, one event
        io_write(16'h7FFD, 8'h2A, 6, 1'b0, 1'b0);
        drain();

        // Lock behaviour on 7FFD
        unlock = 1'b1; io_write(16'h7FFD, 8'h00, 2, 1'b0, 1'b0); unlock = 1'b0;
        io_write(16'h7FFD, 8'h20, 2, 1'b0, 1'b0);
        io_write(16'h7FFD, 8'h07, 2, 1'b0, 1'b0);
        unlock = 1'b1; io_write(16'h7FFD, 8'h07, 2, 1'b0, 1'b0); unlock = 1'b0;
        io_write(16'h7FFD, 8'h11, 2, 1'b0, 1'b0);
        drain();

        // Overflow, sticky flag, clear
        for (int k = 0; k < 5; k++) io_write(16'h00FE, 8'($urandom), 2, 1'b0, 1'b0);
        drain();
        ev_clear = 1'b1; @(negedge clk28); ev_clear = 1'b0;
        m_q.delete(); m_ovf = 1'b0;
        check("clear.ovf", ev_overflow, 1'b0);

        // Full FIFO with push and pop in the same clock
        for (int k = 0; k < 4; k++) io_write(16'h00FE, 8'($urandom), 1, 1'b0, 1'b0);
        io_write(16'h00FE, 8'hC3, 2, 1'b1, 1'b0);
        drain();

        // Clear coinciding with a push discards the push
        io_write(16'h00FE, 8'h5C, 1, 1'b0, 1'b0);
        io_write(16'h7FFD, 8'h01, 2, 1'b0, 1'b1);

        // Readback
        io_write(16'hDFFD, 8'h15, 2, 1'b0, 1'b0);
        io_read(16'hDFFD);
        drain();

        for (int it = 0; it < 80; it++) begin
            en     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            unlock = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0)
                io_read(pool[$urandom_range(0, 5)]);
            else
                io_write(pool[$urandom_range(0, 5)], 8'($urandom), $urandom_range(1, 4),
                         ($urandom_range(0, 2) == 0), ($urandom_range(0, 14) == 0));
            if (it % 6 == 5)
                drain();
        end
        en = 4'hF; unlock = 1'b0;
        drain();

        // Reset in the middle of a write to 1FFD
        bus_a = 16'h1FFD; bus_d = 8'h5A; bus_ioreq = 1'b1; bus_wr = 1'b1;
        repeat (2) @(negedge clk28);
        #5 rst_n = 1'b0;
        #2 check_reset("midrst");
        m_reset();
        @(negedge clk28);
        check_reset("midrst.hold");
        rst_n = 1'b1;
        acc = m_sel(16'h1FFD);
        for (int i = 0; i < NPORTS; i++) stb[i] = 0;
        @(negedge clk28);
        m_commit(acc, 8'h5A, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NPORTS; i++) stb[i] += int'(wr_stb[i]);
            if (c == 2) begin
                bus_ioreq = 1'b0; bus_wr = 1'b0;
            end
            @(negedge clk28);
        end
        for (int i = 0; i < NPORTS; i++) begin
            stb[i] += int'(wr_stb[i]);
            check($sformatf("midrst.stb_count%0d", i), stb[i], int'(acc[i]));
        end
        check_ports("midrst");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
